// File: rtl/uart_tx_arb_pkg.sv
// Shared constants for the UART transmit arbiter.
// State encoding and grant identifiers.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic GNT_BOOT = 1'b0;
  localparam logic GNT_CPU  = 1'b1;

endpackage

// File: rtl/uart_tx_arb_fifo.sv
// Small byte FIFO with sticky overflow flag.
// Head byte is presented combinationally on dout.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic [7:0] din,
  input  logic       rd,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic       ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  // full is the registered value, so a push while full drops even on a pop
  assign push  = wr & ~full;
  assign pop   = rd & ~empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (wr & full) ovf <= 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Shares one UART transmitter between bootloader and CPU I/O.
// Two FIFOs drained one byte at a time by a 3-state scheduler.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       booting,
  input  logic [7:0] boot_data,
  input  logic       boot_wr,
  output logic       boot_full,
  output logic       boot_ovf,
  input  logic [7:0] cpu_data,
  input  logic       cpu_wr,
  output logic       cpu_full,
  output logic       cpu_ovf,
  output logic [7:0] tx_data,
  output logic       tx_wr,
  input  logic       tx_done,
  output logic       busy
);

  state_t     state;
  state_t     nstate;
  logic       last_grant;
  logic       boot_rd;
  logic       cpu_rd;
  logic       boot_empty;
  logic       cpu_empty;
  logic [7:0] boot_head;
  logic [7:0] cpu_head;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_boot_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (boot_wr),
    .din   (boot_data),
    .rd    (boot_rd),
    .dout  (boot_head),
    .empty (boot_empty),
    .full  (boot_full),
    .ovf   (boot_ovf)
  );

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_cpu_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (cpu_wr),
    .din   (cpu_data),
    .rd    (cpu_rd),
    .dout  (cpu_head),
    .empty (cpu_empty),
    .full  (cpu_full),
    .ovf   (cpu_ovf)
  );

  assign tx_wr = (state == ISSUE);
  assign busy  = (state != IDLE);

  always_comb begin
    nstate  = state;
    boot_rd = 1'b0;
    cpu_rd  = 1'b0;
    unique case (state)
      IDLE: begin
        if (booting) begin
          boot_rd = ~boot_empty;
        end else if (last_grant == GNT_CPU) begin
          boot_rd = ~boot_empty;
          cpu_rd  = boot_empty & ~cpu_empty;
        end else begin
          cpu_rd  = ~cpu_empty;
          boot_rd = cpu_empty & ~boot_empty;
        end
        if (boot_rd | cpu_rd) nstate = ISSUE;
      end
      ISSUE:   nstate = WAIT;
      WAIT:    if (tx_done) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GNT_CPU;
      tx_data    <= 8'h00;
    end else begin
      state <= nstate;
      if (boot_rd) begin
        tx_data    <= boot_head;
        last_grant <= GNT_BOOT;
      end else if (cpu_rd) begin
        tx_data    <= cpu_head;
        last_grant <= GNT_CPU;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: queue-based model plus directed scenarios.
// Model is compared every falling edge; literal checks pin it.
module tb_uart_tx_arb;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       booting;
  logic [7:0] boot_data;
  logic       boot_wr;
  logic       boot_full;
  logic       boot_ovf;
  logic [7:0] cpu_data;
  logic       cpu_wr;
  logic       cpu_full;
  logic       cpu_ovf;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_done;
  logic       busy;

  int checks = 0;
  int errors = 0;

  uart_tx_arb #(.FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .booting   (booting),
    .boot_data (boot_data),
    .boot_wr   (boot_wr),
    .boot_full (boot_full),
    .boot_ovf  (boot_ovf),
    .cpu_data  (cpu_data),
    .cpu_wr    (cpu_wr),
    .cpu_full  (cpu_full),
    .cpu_ovf   (cpu_ovf),
    .tx_data   (tx_data),
    .tx_wr     (tx_wr),
    .tx_done   (tx_done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level model: byte queues, a strobe flag, an in-flight flag.
  logic [7:0] bq [$];
  logic [7:0] cq [$];
  logic       m_strobe;
  logic       m_wait;
  logic [7:0] m_data;
  logic       m_last_cpu;
  logic       m_bovf;
  logic       m_covf;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        bq.delete();
        cq.delete();
        m_strobe   = 1'b0;
        m_wait     = 1'b0;
        m_data     = 8'h00;
        m_last_cpu = 1'b1;
        m_bovf     = 1'b0;
        m_covf     = 1'b0;
      end else begin
        automatic bit bf = (bq.size() >= DEPTH);
        automatic bit cf = (cq.size() >= DEPTH);
        automatic int take = 0;
        if (m_strobe) begin
          m_strobe = 1'b0;
          m_wait   = 1'b1;
        end else if (m_wait) begin
          if (tx_done) m_wait = 1'b0;
        end else if (booting) begin
          if (bq.size() > 0) take = 1;
        end else if (m_last_cpu) begin
          if (bq.size() > 0) take = 1;
          else if (cq.size() > 0) take = 2;
        end else begin
          if (cq.size() > 0) take = 2;
          else if (bq.size() > 0) take = 1;
        end
        if (take == 1) begin
          m_data = bq.pop_front();
          m_last_cpu = 1'b0;
          m_strobe = 1'b1;
        end else if (take == 2) begin
          m_data = cq.pop_front();
          m_last_cpu = 1'b1;
          m_strobe = 1'b1;
        end
        if (boot_wr) begin
          if (bf) m_bovf = 1'b1;
          else bq.push_back(boot_data);
        end
        if (cpu_wr) begin
          if (cf) m_covf = 1'b1;
          else cq.push_back(cpu_data);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("mdl_tx_wr", 32'(tx_wr), 32'(m_strobe));
        chk("mdl_busy", 32'(busy), 32'(m_strobe | m_wait));
        chk("mdl_tx_data", 32'(tx_data), 32'(m_data));
        chk("mdl_boot_full", 32'(boot_full), 32'(bq.size() >= DEPTH));
        chk("mdl_cpu_full", 32'(cpu_full), 32'(cq.size() >= DEPTH));
        chk("mdl_boot_ovf", 32'(boot_ovf), 32'(m_bovf));
        chk("mdl_cpu_ovf", 32'(cpu_ovf), 32'(m_covf));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic serve(input string nm, input logic [7:0] exp);
    int n = 0;
    while (!tx_wr && n < 40) begin
      cyc();
      n++;
    end
    if (!tx_wr) begin
      chk({nm, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk(nm, 32'(tx_data), 32'(exp));
      cyc();
      cyc();
      tx_done = 1'b1;
      cyc();
      tx_done = 1'b0;
    end
  endtask

  task automatic quiet(input string nm);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk(nm, 32'(tx_wr), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    booting = 1'b0;
    boot_data = 8'h00;
    boot_wr = 1'b0;
    cpu_data = 8'h00;
    cpu_wr = 1'b0;
    tx_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);

    // single byte latency and hold
    booting = 1'b1;
    boot_data = 8'hA5;
    boot_wr = 1'b1;
    cyc();
    boot_wr = 1'b0;
    chk("lat_n", 32'(tx_wr), 32'd0);
    cyc();
    chk("lat_n1_wr", 32'(tx_wr), 32'd1);
    chk("lat_n1_data", 32'(tx_data), 32'hA5);
    cyc();
    chk("one_shot", 32'(tx_wr), 32'd0);
    cyc();
    cyc();
    chk("hold", 32'(tx_data), 32'hA5);
    tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
    chk("busy_fall", 32'(busy), 32'd0);

    // early tx_done during ISSUE
    boot_data = 8'h77;
    boot_wr = 1'b1;
    cyc();
    boot_wr = 1'b0;
    cyc();
    chk("early_issue", 32'(tx_wr), 32'd1);
    tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
    cyc();
    cyc();
    chk("early_wait", 32'(busy), 32'd1);
    tx_done = 1'b1;
    cyc();
    tx_done = 1'b0;
    chk("early_idle", 32'(busy), 32'd0);

    // round-robin
    do_reset();
    booting = 1'b0;
    cpu_data = 8'h11;
    boot_data = 8'h33;
    cpu_wr = 1'b1;
    boot_wr = 1'b1;
    cyc();
    cpu_data = 8'h22;
    boot_data = 8'h44;
    cyc();
    cpu_wr = 1'b0;
    boot_wr = 1'b0;
    serve("rr0", 8'h33);
    serve("rr1", 8'h11);
    serve("rr2", 8'h44);
    serve("rr3", 8'h22);

    // boot priority
    booting = 1'b1;
    cpu_data = 8'h55;
    boot_data = 8'h66;
    cpu_wr = 1'b1;
    boot_wr = 1'b1;
    cyc();
    cpu_wr = 1'b0;
    boot_wr = 1'b0;
    serve("prio_boot", 8'h66);
    quiet("prio_hold");
    booting = 1'b0;
    serve("prio_cpu", 8'h55);

    // overflow, no drain
    do_reset();
    booting = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_data = 8'hC1 + 8'(i);
      cpu_wr = 1'b1;
      cyc();
      chk("ovf_full", 32'(cpu_full), 32'(i == 3));
    end
    chk("ovf_clear", 32'(cpu_ovf), 32'd0);
    cpu_data = 8'hC5;
    cyc();
    cpu_wr = 1'b0;
    chk("ovf_set", 32'(cpu_ovf), 32'd1);
    booting = 1'b0;
    serve("ovf0", 8'hC1);
    serve("ovf1", 8'hC2);
    serve("ovf2", 8'hC3);
    serve("ovf3", 8'hC4);
    quiet("ovf_absent");

    // push while full in the same cycle as a pop
    do_reset();
    booting = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_data = 8'hD1 + 8'(i);
      cpu_wr = 1'b1;
      cyc();
    end
    booting = 1'b0;
    cpu_data = 8'hEE;
    cyc();
    cpu_wr = 1'b0;
    chk("popdrop_ovf", 32'(cpu_ovf), 32'd1);
    chk("popdrop_full", 32'(cpu_full), 32'd0);
    serve("pd0", 8'hD1);
    serve("pd1", 8'hD2);
    serve("pd2", 8'hD3);
    serve("pd3", 8'hD4);
    quiet("pd_absent");

    // async reset while in WAIT with a full boot FIFO
    booting = 1'b1;
    boot_data = 8'h90;
    boot_wr = 1'b1;
    cyc();
    boot_wr = 1'b0;
    cyc();
    cyc();
    chk("mid_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 5; i++) begin
      boot_data = 8'h91 + 8'(i);
      boot_wr = 1'b1;
      cyc();
    end
    boot_wr = 1'b0;
    chk("mid_bovf", 32'(boot_ovf), 32'd1);
    chk("mid_bfull", 32'(boot_full), 32'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("ar_tx_wr", 32'(tx_wr), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_data", 32'(tx_data), 32'h00);
    chk("ar_bovf", 32'(boot_ovf), 32'd0);
    chk("ar_bfull", 32'(boot_full), 32'd0);
    chk("ar_covf", 32'(cpu_ovf), 32'd0);
    cyc();
    rst = 1'b0;
    quiet("ar_empty");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Transmit-side arbiter that shares the single UART transmitter between the bootloader and the CPU I/O block. Each requester writes bytes into its own small FIFO. A three-state scheduler drains the FIFOs one byte at a time into the UART, issuing a one-cycle `tx_wr` and holding `tx_data` until the UART reports `tx_done`. It sits between `bootloader`/`io` and `uart`, replacing the static `booting` mux on `tx_data`/`tx_wr`.

## Interface
- `FIFO_DEPTH`, default 4: entries per requester FIFO; must be a power of two, at least 2.
- `clk`  in  1  system clock (CLOCK_50 domain); all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `booting`  in  1  1 = bootloader has strict priority and the CPU FIFO is not drained.
- `boot_data`  in  8  bootloader byte.
- `boot_wr`  in  1  one-cycle push strobe for `boot_data`.
- `boot_full`  out  1  bootloader FIFO is full.
- `boot_ovf`  out  1  sticky flag: a bootloader push was dropped.
- `cpu_data`  in  8  CPU/io byte.
- `cpu_wr`  in  1  one-cycle push strobe for `cpu_data`.
- `cpu_full`  out  1  CPU FIFO is full.
- `cpu_ovf`  out  1  sticky flag: a CPU push was dropped.
- `tx_data`  out  8  byte presented to the UART.
- `tx_wr`  out  1  one-cycle transmit strobe to the UART.
- `tx_done`  in  1  UART pulse indicating the byte has finished.
- `busy`  out  1  high when the state is not IDLE.

## Operation
- **FIFOs**
  - A push is accepted when `*_wr`=1 and `*_full`=0, with `*_full` sampled at the start of the cycle.
  - A push while full is dropped and sets `*_ovf`. This holds even if a pop happens in the same cycle.
  - A pop in the same cycle as an accepted push is legal; the count stays unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`. The count is $clog2(FIFO_DEPTH)+1 bits wide.
- **State machine**
  - IDLE
    - If `booting`=1: select boot if its FIFO is non-empty; the CPU FIFO is ignored.
    - If `booting`=0: round-robin. Prefer the source not equal to `last_grant`; fall back to the other source if the preferred one is empty.
    - If a source is selected: pop its head into `tx_data`, update `last_grant`, and go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: `tx_wr`=1 for exactly this cycle, then go to WAIT. A `tx_done` in this cycle is ignored.
  - WAIT: hold `tx_data`. On `tx_done`=1, go to IDLE.
- `tx_data` is stable from the ISSUE cycle through the `tx_done` cycle.
- Toggling `booting` mid-transfer does not abort the byte in flight. It only affects the next IDLE decision.
- `*_ovf` is cleared only by `rst`.

## Timing
- **Reset values:** state=IDLE, `tx_wr`=0, `tx_data`=8'h00, `busy`=0, `*_full`=0, `*_ovf`=0, FIFOs empty, `last_grant`=CPU (so boot wins the first tie).
- **Latency:** a push at edge N into an empty FIFO while IDLE gives a pop at edge N+1 and `tx_wr`=1 during cycle N+2.
- **Back-to-back:** `tx_done` at cycle M gives IDLE at M+1 and the next `tx_wr` at M+2. Minimum spacing is 3 cycles plus the UART time.
- **`*_full`** rises in the cycle after the push that fills the FIFO, and falls in the cycle after the pop.
- **Reset mid-operation:** asynchronous; everything returns to reset values at once; queued bytes are lost; `tx_wr` drops immediately.

## Structure
- **Shared package / constants include:**
  - state encoding: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2
  - grant IDs: GNT_BOOT=1'b0, GNT_CPU=1'b1
- **Sub-module `byte_fifo`:** parameter DEPTH; ports clk, rst, wr, din, rd, dout, empty, full, ovf. Instantiated twice.
- **Top of block:** the FSM, the arbitration logic and the output register.

## Test plan
- **Reset:** assert `rst` while in WAIT → `tx_wr`=0, `busy`=0, `tx_data`=00, both FIFOs empty, `*_ovf`=0.
- **Single byte:** `booting`=1, push boot 8'hA5 at edge N → `tx_wr`=1 during cycle N+2 with `tx_data`=A5; held until `tx_done`; `busy` falls the cycle after `tx_done`.
- **Round-robin:** `booting`=0, CPU pushes 11,22 and boot pushes 33,44 in the same cycles → transmit order 33,11,44,22.
- **Boot priority:** `booting`=1, CPU pushes 55 and boot pushes 66 → only 66 is sent. Drop `booting` → 55 follows.
- **Overflow:** 5 CPU pushes with `FIFO_DEPTH`=4 and no drain → `cpu_full`=1 after the 4th push, `cpu_ovf`=1, 5th byte absent; a push while full in the same cycle as a pop is also dropped.
- **Early `tx_done`:** pulse `tx_done` during ISSUE → ignored; FSM stays in WAIT until the next `tx_done`.
